// File: rtl/seg_scan_mux_if.sv
// seg_scan_mux_if
//   Bundles the update handshake and the display drive of the 4-digit scan
//   controller so the producer and the display side connect through one port.
//   Signals:
//     load       - request to capture value/blank_mask (taken only when ready)
//     value      - four hex nibbles, nibble k shown on digit k
//     blank_mask - bit k = 1 keeps digit k dark for the whole frame
//     ready      - high when no update is pending
//     digit      - nibble of the digit currently being scanned
//     an         - active-low digit enables, at most one bit low
//   Modports:
//     master - the producer/observer side (drives load/value/blank_mask)
//     slave  - the scan controller itself
interface seg_scan_mux_if;
  logic        load;
  logic [15:0] value;
  logic [3:0]  blank_mask;
  logic        ready;
  logic [3:0]  digit;
  logic [3:0]  an;

  modport master (
    output load,
    output value,
    output blank_mask,
    input  ready,
    input  digit,
    input  an
  );

  modport slave (
    input  load,
    input  value,
    input  blank_mask,
    output ready,
    output digit,
    output an
  );
endinterface

// File: rtl/seg_scan_mux.sv
// seg_scan_mux
//   Four-digit time-multiplexed scan controller feeding a 7-segment decoder.
//   Holds a 16-bit hex value and presents one nibble at a time on bus.digit
//   together with the matching active-low enable on bus.an. Updates arrive over
//   a valid/ready handshake and are applied only on a frame boundary, so a
//   frame never mixes old and new digits.
//   Parameters:
//     DIV - clock cycles per digit slot (2..65535)
//   Ports:
//     clk   - system clock, rising edge
//     reset - asynchronous, active-high reset
//     bus   - seg_scan_mux_if.slave (load/value/blank_mask in,
//             ready/digit/an out)
module seg_scan_mux #(
  parameter int unsigned DIV = 4
) (
  input  logic          clk,
  input  logic          reset,
  seg_scan_mux_if.slave bus
);

  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q,       cnt_d;
  logic [1:0]    idx_q,       idx_d;
  logic [15:0]   disp_q,      disp_d;
  logic [3:0]    mask_q,      mask_d;
  logic [15:0]   pend_val_q,  pend_val_d;
  logic [3:0]    pend_mask_q, pend_mask_d;
  logic          pending_q,   pending_d;

  logic slot_tick_s;
  logic boundary_s;
  logic accept_s;

  // Next-state logic: free-running prescaler/digit index plus update handshake.
  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    disp_d      = disp_q;
    mask_d      = mask_q;
    pend_val_d  = pend_val_q;
    pend_mask_d = pend_mask_q;
    pending_d   = pending_q;

    slot_tick_s = (cnt_q == CNT_MAX);
    boundary_s  = slot_tick_s && (idx_q == 2'd3);
    accept_s    = bus.load && !pending_q;

    if (slot_tick_s) begin
      cnt_d = {CW{1'b0}};
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    // Apply and accept are mutually exclusive (one needs pending, the other
    // needs no pending), so a load landing on a boundary with nothing pending
    // is only captured and waits for the next frame.
    if (boundary_s && pending_q) begin
      disp_d    = pend_val_q;
      mask_d    = pend_mask_q;
      pending_d = 1'b0;
    end else if (accept_s) begin
      pend_val_d  = bus.value;
      pend_mask_d = bus.blank_mask;
      pending_d   = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

  // State registers with asynchronous reset; a pending update is discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= {CW{1'b0}};
      idx_q       <= 2'd0;
      disp_q      <= 16'h0000;
      mask_q      <= 4'b0000;
      pend_val_q  <= 16'h0000;
      pend_mask_q <= 4'b0000;
      pending_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      mask_q      <= mask_d;
      pend_val_q  <= pend_val_d;
      pend_mask_q <= pend_mask_d;
      pending_q   <= pending_d;
    end
  end

  // Output decode from registered state only; cnt = 0 blanks each slot start
  // so the previous digit's segments cannot ghost onto the new anode.
  always_comb begin
    bus.ready = !pending_q;
    bus.digit = disp_q[{idx_q, 2'b00} +: 4];
    if ((cnt_q == {CW{1'b0}}) || mask_q[idx_q]) begin
      bus.an = 4'b1111;
    end else begin
      bus.an = ~(4'b0001 << idx_q);
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux
//   Self-checking bench for seg_scan_mux. A reference model tracks the display
//   from the number of clock edges since reset (slot and frame positions are
//   plain division/modulo of that count), directed cases cover the test plan,
//   and a randomized phase exercises the handshake.
module tb_seg_scan_mux;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic clk;
  logic reset;

  seg_scan_mux_if bus ();

  seg_scan_mux #(.DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // model state
  int          n;           // edges since reset release
  logic [15:0] m_disp;
  logic [3:0]  m_mask;
  logic [15:0] m_pval;
  logic [3:0]  m_pmask;
  logic        m_pend;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t n=%0d: got %0h expected %0h", tag, $time, n, obs, exp);
    end
  endtask

  task automatic model_reset();
    n       = 0;
    m_disp  = 16'h0000;
    m_mask  = 4'b0000;
    m_pval  = 16'h0000;
    m_pmask = 4'b0000;
    m_pend  = 1'b0;
  endtask

  task automatic check_outputs();
    int slot_pos;
    int dig;
    logic [3:0] exp_an;
    slot_pos = n % DIV;
    dig      = (n / DIV) % 4;
    if (slot_pos == 0 || m_mask[dig]) exp_an = 4'b1111;
    else exp_an = 4'b1111 & ~(4'(1) << dig);
    check_eq("ready", {31'd0, bus.ready}, {31'd0, !m_pend});
    check_eq("digit", {28'd0, bus.digit}, {28'd0, 4'((m_disp >> (4 * dig)) & 16'h000F)});
    check_eq("an",    {28'd0, bus.an},    {28'd0, exp_an});
  endtask

  // One clock: check at the falling edge, advance the model, step past the rise.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    if ((n % FRAME) == FRAME - 1 && m_pend) begin
      m_disp = m_pval;
      m_mask = m_pmask;
      m_pend = 1'b0;
    end else if (bus.load && !m_pend) begin
      m_pval  = bus.value;
      m_pmask = bus.blank_mask;
      m_pend  = 1'b1;
    end
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cycle();
  endtask

  task automatic load_once(input logic [15:0] v, input logic [3:0] m);
    bus.load       = 1'b1;
    bus.value      = v;
    bus.blank_mask = m;
    cycle();
    bus.load       = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_ready", {31'd0, bus.ready}, 32'd1);
    check_eq("rst_digit", {28'd0, bus.digit}, 32'd0);
    check_eq("rst_an",    {28'd0, bus.an},    32'hF);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    bus.load       = 1'b0;
    bus.value      = 16'h0000;
    bus.blank_mask = 4'b0000;
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // idle after reset
    run(40);

    // basic load on the first cycle after reset
    do_reset();
    load_once(16'h1234, 4'b0000);
    run(35);

    // busy ignore: second load while pending must be dropped
    load_once(16'hABCD, 4'b0000);
    run(2);
    load_once(16'h5555, 4'b0000);
    run(40);

    // boundary collision with nothing pending
    while ((n % FRAME) != FRAME - 1) cycle();
    load_once(16'hBEEF, 4'b0000);
    run(40);

    // blanking of digits 2 and 3
    load_once(16'h0042, 4'b1100);
    run(40);

    // asynchronous reset mid-slot with an update pending
    load_once(16'h7777, 4'b0000);
    while ((n % DIV) != 2) cycle();
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_ready", {31'd0, bus.ready}, 32'd1);
    check_eq("async_digit", {28'd0, bus.digit}, 32'd0);
    check_eq("async_an",    {28'd0, bus.an},    32'hF);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    run(40);

    // randomized handshake traffic
    for (int i = 0; i < 600; i++) begin
      bus.load       = ($urandom_range(0, 3) == 0);
      bus.value      = 16'($urandom);
      bus.blank_mask = 4'($urandom);
      cycle();
    end
    bus.load = 1'b0;
    run(2 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
